// File: rtl/rotation_pkg.sv
// Shared types and constants for the rotor-synchronous frame scheduler.
package rotation_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_t;

  localparam int SYNC_STAGES = 2;

  // Smallest r with 2**r >= value; exact for the power-of-two slice counts used here.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous rotor index into the clock domain and emits a
// one-cycle pulse on each rising edge.
module edge_sync
  import rotation_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      prev <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/rotation_scheduler.sv
// Measures the rotor revolution period and steps frame_num once per angular
// slice so every frame is drawn at a fixed angle.
module rotation_scheduler
  import rotation_pkg::*;
#(
  parameter int SLICES     = 8,
  parameter int PERIOD_W   = 24,
  parameter int FRAME_W    = 8,
  parameter int MIN_PERIOD = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clock_cycle,
  output logic [FRAME_W-1:0]  frame_num,
  output logic                frame_start,
  output logic                locked,
  output logic [PERIOD_W-1:0] period
);

  localparam int                  SHIFT      = log2(SLICES);
  localparam logic [PERIOD_W-1:0] CNT_MAX    = '1;
  localparam logic [PERIOD_W-1:0] MIN_CNT    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);
  localparam logic [FRAME_W-1:0]  LAST_FRAME = FRAME_W'(SLICES - 1);

  logic                index_edge;
  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] tmr;
  logic [PERIOD_W-1:0] slice_len;
  logic                accept;
  logic                cnt_sat;

  edge_sync u_edge_sync (
    .clock (clock),
    .reset (reset),
    .in    (clock_cycle),
    .rise  (index_edge)
  );

  // Edges arriving too soon after the last accepted one are sensor glitches.
  assign accept  = index_edge && (state != IDLE) && (cnt >= MIN_CNT);
  assign cnt_sat = (cnt == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      slice_len   <= '0;
      frame_num   <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      period      <= '0;
    end else begin
      frame_start <= 1'b0;
      if (!cnt_sat) cnt <= cnt + ONE;

      case (state)
        IDLE: begin
          if (index_edge) begin
            cnt   <= ONE;
            state <= MEASURE;
          end
        end

        MEASURE, RUN: begin
          if (accept) begin
            period      <= cnt;
            slice_len   <= cnt >> SHIFT;
            frame_num   <= '0;
            tmr         <= ONE;
            frame_start <= 1'b1;
            cnt         <= ONE;
            locked      <= 1'b1;
            state       <= RUN;
          end else if (cnt_sat) begin
            // Rotor stopped or lost: drop lock and wait for a fresh measurement.
            state     <= IDLE;
            locked    <= 1'b0;
            frame_num <= '0;
            period    <= '0;
          end else if (state == RUN) begin
            // The last frame never advances; it soaks up remainder and slowdown.
            if ((tmr == slice_len) && (frame_num < LAST_FRAME)) begin
              frame_num   <= frame_num + 1'b1;
              tmr         <= ONE;
              frame_start <= 1'b1;
            end else begin
              tmr <= tmr + ONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_scheduler.sv
// Randomized bench for rotation_scheduler against a timeline-based reference model.
module tb_rotation_scheduler;

  localparam int SLICES     = 8;
  localparam int PERIOD_W   = 16;
  localparam int FRAME_W    = 8;
  localparam int MIN_PERIOD = 64;
  localparam int CNT_MAX    = (1 << PERIOD_W) - 1;

  logic                clock;
  logic                reset;
  logic                clock_cycle;
  logic [FRAME_W-1:0]  frame_num;
  logic                frame_start;
  logic                locked;
  logic [PERIOD_W-1:0] period;

  rotation_scheduler #(
    .SLICES     (SLICES),
    .PERIOD_W   (PERIOD_W),
    .FRAME_W    (FRAME_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clock_cycle (clock_cycle),
    .frame_num   (frame_num),
    .frame_start (frame_start),
    .locked      (locked),
    .period      (period)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   cyc;
  int   checks;
  int   errors;
  int   edge_q[$];
  logic last_level;

  // Model: 0 = no reference edge, 1 = one reference edge, 2 = locked.
  int m_mode;
  int m_ref;
  int m_acc;
  int m_period;
  int m_slice;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Applies the index-edge rules for the clock edge numbered cyc.
  task automatic model_update();
    bit e;
    e = (edge_q.size() > 0) && (edge_q[0] == cyc);
    if (e) void'(edge_q.pop_front());
    if (m_mode == 0) begin
      if (e) begin
        m_mode = 1;
        m_ref  = cyc;
      end
    end else if (e && (cyc - m_ref >= MIN_PERIOD)) begin
      m_period = cyc - m_ref;
      m_slice  = m_period / SLICES;
      m_acc    = cyc;
      m_ref    = cyc;
      m_mode   = 2;
    end else if (cyc - m_ref == CNT_MAX) begin
      m_mode = 0;
    end
  endtask

  task automatic compare_all();
    bit lk;
    int el;
    int k;
    lk = (m_mode == 2);
    el = lk ? (cyc - m_acc) : 0;
    k  = lk ? el / m_slice : 0;
    check("locked", 32'(locked), 32'(lk));
    check("period", 32'(period), lk ? m_period : 0);
    check("frame_num", 32'(frame_num), (k > SLICES - 1) ? SLICES - 1 : k);
    check("frame_start", 32'(frame_start),
          32'(lk && (el % m_slice == 0) && (k <= SLICES - 1)));
  endtask

  // One clock: advance model, drive the index line, then check at the falling edge.
  task automatic step(input logic level);
    @(posedge clock);
    cyc++;
    model_update();
    #1;
    clock_cycle = level;
    if (level && !last_level) edge_q.push_back(cyc + 4);
    last_level = level;
    #4;
    compare_all();
  endtask

  // One index pulse 4 clocks wide, p clocks rise-to-rise, optional extra pulse at offset g.
  task automatic revolution(input int p, input int g);
    for (int i = 0; i < p; i++)
      step((i < 4) || (g > 0 && i >= g && i < g + 3));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Asserts reset between clock edges and checks the outputs drop without a clock.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_frame_num", 32'(frame_num), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_period", 32'(period), 0);
    m_mode = 0;
    edge_q.delete();
    @(posedge clock);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int p;
    int g;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    m_mode      = 0;
    m_ref       = 0;
    m_acc       = 0;
    m_period    = 0;
    m_slice     = 1;
    last_level  = 1'b0;
    clock_cycle = 1'b0;
    reset       = 1'b0;

    do_reset();
    idle_cycles(5);

    // Steady 800-clock revolutions.
    for (int i = 0; i < 3; i++) revolution(800, 0);
    check("period_800", 32'(period), 800);
    check("locked_800", 32'(locked), 1);

    // 803: frame 7 takes the 3-cycle remainder.
    for (int i = 0; i < 2; i++) revolution(803, 0);
    check("period_803", 32'(period), 803);

    // Extra pulse 20 clocks after the index is a glitch.
    revolution(800, 20);
    revolution(800, 20);
    check("period_glitch", 32'(period), 800);

    // Slowdown: frame 7 held for the extra 200 clocks.
    revolution(1000, 0);
    check("hold_frame7", 32'(frame_num), 7);
    revolution(800, 0);
    check("period_1000", 32'(period), 1000);

    // Random speeds with random extra pulses, plus a too-short revolution.
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(100, 900);
      g = ($urandom_range(0, 1) == 1) ? $urandom_range(6, p - 10) : 0;
      revolution(p, g);
    end
    revolution(40, 0);
    revolution(600, 0);

    // Reset in the middle of a locked revolution; relock needs two pulses.
    revolution(800, 0);
    idle_cycles(100);
    do_reset();
    revolution(800, 0);
    check("relock_one_pulse", 32'(locked), 0);
    revolution(800, 0);
    check("relock_two_pulses", 32'(locked), 1);
    revolution(800, 0);

    // Pulses stop: counter saturates and lock is dropped.
    idle_cycles(65600);
    check("sat_locked", 32'(locked), 0);
    check("sat_period", 32'(period), 0);
    check("sat_frame_num", 32'(frame_num), 0);
    revolution(200, 0);
    revolution(200, 0);
    check("sat_relock", 32'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
